// File: rtl/sync_ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: port indices and the
// round-robin pointer helper.
package sync_ram_arbiter_pkg;

  localparam logic PORT0  = 1'b0;
  localparam logic PORT1  = 1'b1;
  localparam int   NPORTS = 2;

  // After serving a port, priority passes to the other one.
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/SYNC_RAM.sv
// Single-ported RAM with synchronous read: read data for the address
// presented in cycle t appears in cycle t+1 (read-before-write).
module SYNC_RAM #(
  parameter int DWIDTH            = 32,
  parameter int AWIDTH            = 10,
  parameter int DEPTH             = 1024,
  parameter     MEM_INIT_HEX_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sync_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between two clients,
// with a one-entry read response buffer per client.
module sync_ram_arbiter
  import sync_ram_arbiter_pkg::*;
#(
  parameter int DWIDTH            = 32,
  parameter int AWIDTH            = 10,
  parameter int DEPTH             = 1024,
  parameter     MEM_INIT_HEX_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [AWIDTH-1:0] p0_req_addr,
  input  logic [DWIDTH-1:0] p0_req_wdata,
  output logic              p0_resp_valid,
  input  logic              p0_resp_ready,
  output logic [DWIDTH-1:0] p0_resp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [AWIDTH-1:0] p1_req_addr,
  input  logic [DWIDTH-1:0] p1_req_wdata,
  output logic              p1_resp_valid,
  input  logic              p1_resp_ready,
  output logic [DWIDTH-1:0] p1_resp_rdata
);

  // Handshakes: a request transfers in the cycle req_valid && req_ready;
  // a response transfers in the cycle resp_valid && resp_ready. Neither
  // side latches anything before its transfer cycle.

  logic [NPORTS-1:0] req_valid;
  logic [NPORTS-1:0] req_we;
  logic [NPORTS-1:0] resp_ready;
  logic [AWIDTH-1:0] req_addr  [NPORTS];
  logic [DWIDTH-1:0] req_wdata [NPORTS];

  assign req_valid    = {p1_req_valid, p0_req_valid};
  assign req_we       = {p1_req_we, p0_req_we};
  assign resp_ready   = {p1_resp_ready, p0_resp_ready};
  assign req_addr[0]  = p0_req_addr;
  assign req_addr[1]  = p1_req_addr;
  assign req_wdata[0] = p0_req_wdata;
  assign req_wdata[1] = p1_req_wdata;

  logic              ptr;
  logic [NPORTS-1:0] inflight;
  logic [NPORTS-1:0] buf_full;
  logic [DWIDTH-1:0] buf_q [NPORTS];
  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] grant;
  logic              grant_any;
  logic              grant_port;
  logic              ram_we;
  logic [AWIDTH-1:0] ram_addr;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] ram_wdata;
  logic [DWIDTH-1:0] ram_rdata;

  // A read may only start when its response has somewhere to land: nothing
  // in flight, and the buffer either empty or being drained this cycle.
  always_comb begin
    eligible = '0;
    for (int n = 0; n < NPORTS; n++) begin
      eligible[n] = req_valid[n] &
                    (req_we[n] | (~inflight[n] & (~buf_full[n] | resp_ready[n])));
    end
  end

  always_comb begin
    grant = '0;
    if (eligible[PORT0] && (!eligible[PORT1] || ptr == PORT0)) begin
      grant[PORT0] = 1'b1;
    end else if (eligible[PORT1]) begin
      grant[PORT1] = 1'b1;
    end
  end

  assign grant_any  = |grant;
  assign grant_port = grant[PORT1] ? PORT1 : PORT0;

  // The address register keeps the RAM address stable while idle; a write
  // coinciding with reset never reaches the array.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = req_wdata[grant_port];
    if (grant_any) begin
      ram_addr = req_addr[grant_port];
      ram_we   = req_we[grant_port] & ~rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= PORT0;
      inflight <= '0;
      buf_full <= '0;
      addr_q   <= '0;
      for (int n = 0; n < NPORTS; n++) begin
        buf_q[n] <= '0;
      end
    end else begin
      if (grant_any) begin
        ptr    <= other_port(grant_port);
        addr_q <= ram_addr;
      end
      for (int n = 0; n < NPORTS; n++) begin
        inflight[n] <= grant[n] & ~req_we[n];
        if (inflight[n]) begin
          buf_q[n]    <= ram_rdata;
          buf_full[n] <= 1'b1;
        end else if (buf_full[n] && resp_ready[n]) begin
          buf_full[n] <= 1'b0;
        end
      end
    end
  end

  assign p0_req_ready  = grant[PORT0];
  assign p1_req_ready  = grant[PORT1];
  assign p0_resp_valid = buf_full[PORT0];
  assign p1_resp_valid = buf_full[PORT1];
  assign p0_resp_rdata = buf_q[PORT0];
  assign p1_resp_rdata = buf_q[PORT1];

  SYNC_RAM #(
    .DWIDTH            (DWIDTH),
    .AWIDTH            (AWIDTH),
    .DEPTH             (DEPTH),
    .MEM_INIT_HEX_FILE (MEM_INIT_HEX_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Directed bench for sync_ram_arbiter: reset, read-after-write, alternating
// writes, response backpressure, full utilisation, reset mid-read, idle.
`timescale 1ns/1ps
module tb_sync_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req_valid, p0_req_ready, p0_req_we;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata;
  logic          p0_resp_valid, p0_resp_ready;
  logic [DW-1:0] p0_resp_rdata;
  logic          p1_req_valid, p1_req_ready, p1_req_we;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata;
  logic          p1_resp_valid, p1_resp_ready;
  logic [DW-1:0] p1_resp_rdata;

  int total = 0;
  int fails = 0;

  sync_ram_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(1024), .MEM_INIT_HEX_FILE("")) dut (
    .clk           (clk),
    .rst           (rst),
    .p0_req_valid  (p0_req_valid),
    .p0_req_ready  (p0_req_ready),
    .p0_req_we     (p0_req_we),
    .p0_req_addr   (p0_req_addr),
    .p0_req_wdata  (p0_req_wdata),
    .p0_resp_valid (p0_resp_valid),
    .p0_resp_ready (p0_resp_ready),
    .p0_resp_rdata (p0_resp_rdata),
    .p1_req_valid  (p1_req_valid),
    .p1_req_ready  (p1_req_ready),
    .p1_req_we     (p1_req_we),
    .p1_req_addr   (p1_req_addr),
    .p1_req_wdata  (p1_req_wdata),
    .p1_resp_valid (p1_resp_valid),
    .p1_resp_ready (p1_resp_ready),
    .p1_resp_rdata (p1_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
  endtask

  task automatic drive1(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
  endtask

  // A capture and a pop must never hit the same buffer in one cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("pop_capture_p0", DW'(dut.inflight[0] & dut.buf_full[0] & p0_resp_ready), '0);
      chk("pop_capture_p1", DW'(dut.inflight[1] & dut.buf_full[1] & p1_resp_ready), '0);
    end
  end

  initial begin
    rst = 1'b1;
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0);
    p0_resp_ready = 1'b1;
    p1_resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid0", DW'(p0_resp_valid), '0);
    chk("rst_valid1", DW'(p1_resp_valid), '0);
    chk("rst_rdata0", p0_resp_rdata, '0);
    chk("rst_rdata1", p1_resp_rdata, '0);
    chk("rst_ptr", DW'(dut.ptr), '0);

    // Write then read-back on p0.
    drive0(1, 1, AW'(5), 32'hDEADBEEF);
    #1;
    chk("t1_wr_ready0", DW'(p0_req_ready), 32'd1);
    chk("t1_wr_ready1", DW'(p1_req_ready), '0);
    chk("t1_wr_we", DW'(dut.ram_we), 32'd1);
    tick();
    drive0(1, 0, AW'(5), '0);
    #1;
    chk("t1_rd_ready0", DW'(p0_req_ready), 32'd1);
    chk("t1_t1_valid0", DW'(p0_resp_valid), '0);
    tick();
    drive0(0, 0, '0, '0);
    #1;
    chk("t1_t2_valid0", DW'(p0_resp_valid), '0);
    chk("t1_t2_rdata0", p0_resp_rdata, '0);
    tick();
    chk("t1_t3_valid0", DW'(p0_resp_valid), 32'd1);
    chk("t1_t3_rdata0", p0_resp_rdata, 32'hDEADBEEF);
    tick();
    chk("t1_popped0", DW'(p0_resp_valid), '0);

    // Simultaneous writes from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t2_ptr", DW'(dut.ptr), '0);
    for (int i = 0; i < 6; i++) begin
      drive0(1, 1, AW'(20), DW'(32'hA0 + i));
      drive1(1, 1, AW'(21), DW'(32'hB0 + i));
      #1;
      chk("t2_ready0", DW'(p0_req_ready), DW'(i % 2 == 0));
      chk("t2_ready1", DW'(p1_req_ready), DW'(i % 2 == 1));
      tick();
    end
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0);
    #1;
    chk("t2_mem20", dut.u_ram.mem[20], 32'hA4);
    chk("t2_mem21", dut.u_ram.mem[21], 32'hB5);

    // Backpressure on p1.
    drive0(1, 1, AW'(3), 32'h33);
    tick();
    drive0(1, 1, AW'(4), 32'h44);
    tick();
    drive0(0, 0, '0, '0);
    p1_resp_ready = 1'b0;
    drive1(1, 0, AW'(3), '0);
    #1;
    chk("t3_rd_ready1", DW'(p1_req_ready), 32'd1);
    tick();
    drive1(1, 0, AW'(4), '0);
    #1;
    chk("t3_inflight_ready1", DW'(p1_req_ready), '0);
    tick();
    for (int j = 0; j < 10; j++) begin
      if (j == 5) begin
        drive1(1, 1, AW'(7), 32'h77);
        #1;
        chk("t3_wr_ready1", DW'(p1_req_ready), 32'd1);
      end else begin
        drive1(1, 0, AW'(4), '0);
        #1;
        chk("t3_stall_ready1", DW'(p1_req_ready), '0);
      end
      chk("t3_hold_valid1", DW'(p1_resp_valid), 32'd1);
      chk("t3_hold_rdata1", p1_resp_rdata, 32'h33);
      tick();
    end
    drive1(1, 0, AW'(4), '0);
    p1_resp_ready = 1'b1;
    #1;
    chk("t3_drain_ready1", DW'(p1_req_ready), 32'd1);
    chk("t3_drain_rdata1", p1_resp_rdata, 32'h33);
    tick();
    drive1(0, 0, '0, '0);
    #1;
    chk("t3_after_pop_valid1", DW'(p1_resp_valid), '0);
    tick();
    chk("t3_next_valid1", DW'(p1_resp_valid), 32'd1);
    chk("t3_next_rdata1", p1_resp_rdata, 32'h44);
    tick();
    chk("t3_mem7", dut.u_ram.mem[7], 32'h77);

    // Full utilisation: preload, then both ports read back to back.
    for (int i = 0; i < 8; i++) begin
      drive1(1, 1, AW'(40 + i), DW'(32'h1000 + 3 * i));
      tick();
    end
    drive1(1, 1, AW'(50), 32'h50);
    tick();
    begin
      int k0 = 0;
      int k1 = 0;
      for (int c = 0; c < 11; c++) begin
        if (c < 8) begin
          drive0(1, 0, AW'(40 + 2 * k0), '0);
          drive1(1, 0, AW'(41 + 2 * k1), '0);
        end else begin
          drive0(0, 0, '0, '0);
          drive1(0, 0, '0, '0);
        end
        #1;
        chk("t4_ready0", DW'(p0_req_ready), DW'(c < 8 && c % 2 == 0));
        chk("t4_ready1", DW'(p1_req_ready), DW'(c < 8 && c % 2 == 1));
        chk("t4_valid0", DW'(p0_resp_valid), DW'(c >= 2 && c <= 8 && c % 2 == 0));
        chk("t4_valid1", DW'(p1_resp_valid), DW'(c >= 3 && c <= 9 && c % 2 == 1));
        if (c >= 2 && c <= 8 && c % 2 == 0) chk("t4_rdata0", p0_resp_rdata, DW'(32'h1000 + 3 * (c - 2)));
        if (c >= 3 && c <= 9 && c % 2 == 1) chk("t4_rdata1", p1_resp_rdata, DW'(32'h1000 + 3 * (c - 2)));
        if (c % 2 == 0) k0++;
        else k1++;
        tick();
      end
    end

    // Reset arriving one cycle after a read grant, with a p1 write pending.
    drive0(1, 0, AW'(40), '0);
    #1;
    chk("t5_rd_ready0", DW'(p0_req_ready), 32'd1);
    tick();
    drive0(0, 0, '0, '0);
    drive1(1, 1, AW'(50), 32'h55);
    rst = 1'b1;
    #1;
    chk("t5_rst_we", DW'(dut.ram_we), '0);
    tick();
    rst = 1'b0;
    drive1(0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_valid0", DW'(p0_resp_valid), '0);
      chk("t5_rdata0", p0_resp_rdata, '0);
      chk("t5_rdata1", p1_resp_rdata, '0);
      chk("t5_ptr", DW'(dut.ptr), '0);
      tick();
    end
    chk("t5_mem50", dut.u_ram.mem[50], 32'h50);

    // Idle.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_we", DW'(dut.ram_we), '0);
      chk("t6_ptr", DW'(dut.ptr), '0);
      chk("t6_valid0", DW'(p0_resp_valid), '0);
      chk("t6_valid1", DW'(p1_resp_valid), '0);
      tick();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
